// File: rtl/rf_write_port.sv
// Write-side front end of the 16x16 register file: handshake intake, small FIFO,
// registered one-hot write stage, plus pending-write mask and read bypass for in-flight writes.
module rf_write_port #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDR_W-1:0]      wr_reg_id,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rf_stall,
  output logic                   rf_write_en,
  output logic [(2**ADDR_W)-1:0] rf_wordline,
  output logic [DATA_W-1:0]      rf_bitline,
  output logic [(2**ADDR_W)-1:0] pending,
  output logic [ADDR_W-1:0]      fifo_count,
  input  logic [ADDR_W-1:0]      rd_reg_id,
  output logic                   byp_hit,
  output logic [DATA_W-1:0]      byp_data
);

  localparam int NREG  = 2**ADDR_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] id);
    onehot     = '0;
    onehot[id] = 1'b1;
  endfunction

  logic [ADDR_W-1:0] id_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push, pop;

  logic              vld_p1;
  logic [NREG-1:0]   wl_p1;
  logic [DATA_W-1:0] data_p1;

  // R0 writes complete the handshake but are never queued.
  assign wr_ready = (count < CNT_W'(DEPTH));
  assign push     = wr_valid & wr_ready & (wr_reg_id != '0);
  assign pop      = (count != '0) & ~rf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_ptr]   <= wr_reg_id;
      data_mem[wr_ptr] <= wr_data;
    end
  end

  // Stage p1: registered write to the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      wl_p1   <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= pop;
      wl_p1  <= pop ? onehot(id_mem[rd_ptr]) : '0;
      if (pop) data_p1 <= data_mem[rd_ptr];
    end
  end

  assign rf_write_en = vld_p1;
  assign rf_wordline = wl_p1;
  assign rf_bitline  = data_p1;
  assign fifo_count  = ADDR_W'(count);

  // Walk oldest to newest after the output stage so the newest match wins.
  always_comb begin
    logic [PTR_W-1:0] slot;
    slot     = '0;
    pending  = wl_p1;
    byp_hit  = 1'b0;
    byp_data = '0;
    if (rd_reg_id != '0 && wl_p1[rd_reg_id]) begin
      byp_hit  = 1'b1;
      byp_data = data_p1;
    end
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < count) begin
        pending = pending | onehot(id_mem[slot]);
        if (rd_reg_id != '0 && id_mem[slot] == rd_reg_id) begin
          byp_hit  = 1'b1;
          byp_data = data_mem[slot];
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_write_port.sv
// Bench for rf_write_port: vector table plus directed sequences; a scoreboard queue
// holds expected register-file writes and a monitor compares them as they commit.
module tb_rf_write_port;

  logic        clk, rst_n;
  logic        wr_valid, wr_ready, rf_stall, rf_write_en, byp_hit;
  logic [3:0]  wr_reg_id, fifo_count, rd_reg_id;
  logic [15:0] wr_data, rf_wordline, rf_bitline, pending, byp_data;

  rf_write_port dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_reg_id(wr_reg_id), .wr_data(wr_data), .rf_stall(rf_stall),
    .rf_write_en(rf_write_en), .rf_wordline(rf_wordline), .rf_bitline(rf_bitline),
    .pending(pending), .fifo_count(fifo_count), .rd_reg_id(rd_reg_id),
    .byp_hit(byp_hit), .byp_data(byp_data)
  );

  typedef struct {
    logic [3:0]  id;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic [3:0]  id;
    logic [15:0] data;
    logic [3:0]  rd;
    logic [3:0]  cnt;
    logic [15:0] pend;
    logic        hit;
    logic [15:0] bdata;
  } vec_t;

  exp_t exp_q[$];
  vec_t vt[5];
  int   checks   = 0;
  int   failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every cycle with rf_write_en high is one RF commit.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (rf_write_en) begin
        if (exp_q.size() == 0) begin
          chk("rf_write_unexpected", {16'h0, rf_wordline}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("rf_wordline", {16'h0, rf_wordline}, {16'h0, 16'(16'h1 << e.id)});
          chk("rf_bitline", {16'h0, rf_bitline}, {16'h0, e.data});
        end
      end else begin
        chk("rf_wordline_idle", {16'h0, rf_wordline}, 32'h0);
      end
    end
  end

  task automatic send(input logic [3:0] id, input logic [15:0] d);
    int n;
    n = 0;
    wr_valid  = 1'b1;
    wr_reg_id = id;
    wr_data   = d;
    #1;
    while (!wr_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("send_ready", {31'h0, wr_ready}, 32'h1);
    if (wr_ready && id != 4'd0) exp_q.push_back('{id, d});
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && fifo_count == 4'd0 && !rf_write_en) break;
      @(negedge clk);
    end
    chk("drain_done", {31'h0, (exp_q.size() == 0 && fifo_count == 4'd0 && !rf_write_en)}, 32'h1);
  endtask

  initial begin
    int cnt_m;
    logic [3:0] rid;
    logic [15:0] rdat;

    vt[0] = '{4'd5,  16'hBEEF, 4'd5,  4'd1, 16'h0020, 1'b1, 16'hBEEF};
    vt[1] = '{4'd0,  16'h1234, 4'd0,  4'd0, 16'h0000, 1'b0, 16'h0000};
    vt[2] = '{4'd15, 16'hFFFF, 4'd15, 4'd1, 16'h8000, 1'b1, 16'hFFFF};
    vt[3] = '{4'd1,  16'h0001, 4'd2,  4'd1, 16'h0002, 1'b0, 16'h0000};
    vt[4] = '{4'd0,  16'h5555, 4'd5,  4'd0, 16'h0000, 1'b0, 16'h0000};

    rst_n = 1'b0; wr_valid = 1'b0; wr_reg_id = '0; wr_data = '0;
    rf_stall = 1'b0; rd_reg_id = '0;

    // Reset state
    @(negedge clk);
    chk("rst_write_en", {31'h0, rf_write_en}, 32'h0);
    chk("rst_wordline", {16'h0, rf_wordline}, 32'h0);
    chk("rst_bitline", {16'h0, rf_bitline}, 32'h0);
    chk("rst_pending", {16'h0, pending}, 32'h0);
    chk("rst_ready", {31'h0, wr_ready}, 32'h1);
    chk("rst_count", {28'h0, fifo_count}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write latency
    send(4'd5, 16'hBEEF);
    chk("single_pending_q", {16'h0, pending}, 32'h0020);
    chk("single_count_q", {28'h0, fifo_count}, 32'h1);
    chk("single_en_early", {31'h0, rf_write_en}, 32'h0);
    @(negedge clk);
    chk("single_en", {31'h0, rf_write_en}, 32'h1);
    chk("single_wordline", {16'h0, rf_wordline}, 32'h0020);
    chk("single_bitline", {16'h0, rf_bitline}, 32'hBEEF);
    chk("single_pending_out", {16'h0, pending}, 32'h0020);
    @(negedge clk);
    chk("single_en_done", {31'h0, rf_write_en}, 32'h0);
    chk("single_bitline_hold", {16'h0, rf_bitline}, 32'hBEEF);
    chk("single_pending_done", {16'h0, pending}, 32'h0);
    wait_drain();

    // R0 discard
    send(4'd0, 16'h1234);
    for (int i = 0; i < 3; i++) begin
      chk("r0_ready", {31'h0, wr_ready}, 32'h1);
      chk("r0_count", {28'h0, fifo_count}, 32'h0);
      chk("r0_en", {31'h0, rf_write_en}, 32'h0);
      chk("r0_pending", {16'h0, pending}, 32'h0);
      @(negedge clk);
    end

    // Vector table: queue one write under stall, inspect, then drain
    for (int v = 0; v < 5; v++) begin
      rf_stall = 1'b1;
      send(vt[v].id, vt[v].data);
      rd_reg_id = vt[v].rd;
      #1;
      chk("vec_count", {28'h0, fifo_count}, {28'h0, vt[v].cnt});
      chk("vec_pending", {16'h0, pending}, {16'h0, vt[v].pend});
      chk("vec_byp_hit", {31'h0, byp_hit}, {31'h0, vt[v].hit});
      chk("vec_byp_data", {16'h0, byp_data}, {16'h0, vt[v].bdata});
      rf_stall = 1'b0;
      wait_drain();
    end

    // Back-pressure
    rf_stall = 1'b1;
    send(4'd1, 16'h1111);
    send(4'd2, 16'h2222);
    wr_valid = 1'b1; wr_reg_id = 4'd3; wr_data = 16'h3333;
    #1;
    chk("bp_ready_full", {31'h0, wr_ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_count_hold", {28'h0, fifo_count}, 32'h2);
      chk("bp_en_stalled", {31'h0, rf_write_en}, 32'h0);
      chk("bp_pending", {16'h0, pending}, 32'h0006);
    end
    rf_stall = 1'b0;
    send(4'd3, 16'h3333);
    wait_drain();

    // Bypass priority
    rf_stall = 1'b1;
    send(4'd7, 16'h0001);
    send(4'd7, 16'h0002);
    rd_reg_id = 4'd7; #1;
    chk("byp_newest_hit", {31'h0, byp_hit}, 32'h1);
    chk("byp_newest_data", {16'h0, byp_data}, 32'h0002);
    rd_reg_id = 4'd8; #1;
    chk("byp_miss_hit", {31'h0, byp_hit}, 32'h0);
    chk("byp_miss_data", {16'h0, byp_data}, 32'h0);
    rd_reg_id = 4'd0; #1;
    chk("byp_r0_hit", {31'h0, byp_hit}, 32'h0);
    rd_reg_id = 4'd7;
    rf_stall = 1'b0;
    @(negedge clk);
    rf_stall = 1'b1; #1;
    chk("byp_fifo_over_out", {16'h0, byp_data}, 32'h0002);
    @(negedge clk);
    rf_stall = 1'b0;
    @(negedge clk);
    #1;
    chk("byp_out_hit", {31'h0, byp_hit}, 32'h1);
    chk("byp_out_data", {16'h0, byp_data}, 32'h0002);
    @(negedge clk);
    #1;
    chk("byp_gone_hit", {31'h0, byp_hit}, 32'h0);
    chk("byp_gone_data", {16'h0, byp_data}, 32'h0);
    wait_drain();

    // Push+pop streaming at count 1
    send(4'd4, 16'h4444);
    cnt_m = 1;
    for (int i = 0; i < 20; i++) begin
      rid  = 4'($urandom_range(0, 15));
      rdat = 16'($urandom);
      wr_valid = 1'b1; wr_reg_id = rid; wr_data = rdat;
      #1;
      chk("stream_ready", {31'h0, wr_ready}, 32'h1);
      if (rid != 4'd0) exp_q.push_back('{rid, rdat});
      cnt_m = cnt_m - ((cnt_m > 0) ? 1 : 0) + ((rid != 4'd0) ? 1 : 0);
      @(negedge clk);
      chk("stream_count", {28'h0, fifo_count}, cnt_m);
    end
    wr_valid = 1'b0;
    wait_drain();

    // Reset mid-operation with FIFO full
    rf_stall = 1'b1;
    send(4'd9, 16'h9999);
    send(4'd10, 16'hAAAA);
    rd_reg_id = 4'd9; #1;
    chk("mid_pending_full", {16'h0, pending}, 32'h0600);
    chk("mid_byp_before", {31'h0, byp_hit}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_en", {31'h0, rf_write_en}, 32'h0);
    chk("mid_rst_wordline", {16'h0, rf_wordline}, 32'h0);
    chk("mid_rst_bitline", {16'h0, rf_bitline}, 32'h0);
    chk("mid_rst_pending", {16'h0, pending}, 32'h0);
    chk("mid_rst_byp_hit", {31'h0, byp_hit}, 32'h0);
    chk("mid_rst_byp_data", {16'h0, byp_data}, 32'h0);
    chk("mid_rst_ready", {31'h0, wr_ready}, 32'h1);
    chk("mid_rst_count", {28'h0, fifo_count}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rf_stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mid_no_write", {31'h0, rf_write_en}, 32'h0);
    end

    chk("sb_empty", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
